sevenseg_scan_ctrl: RTL

//  Parametrised multiplexed seven-segment scan controller for the Nexys4 display path.

---
 rtl/sevenseg_pkg.sv | 37 +++
 rtl/sevenseg_glyph_dec.sv | 13 +
 rtl/sevenseg_scan_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - glyph codes, segment table and scan FSM encoding for the seven-segment scanner
package sevenseg_pkg;

    localparam logic [4:0] GLYPH_BLANK = 5'h10;
    localparam logic [4:0] GLYPH_DASH  = 5'h11;
    localparam logic [4:0] GLYPH_L     = 5'h12;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_L    = 7'h47;

    // Active-low, bit 0 = segment a ... bit 6 = segment g
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    function automatic logic [6:0] glyph_to_seg(input logic [4:0] glyph);
        logic [6:0] seg;
        if (!glyph[4]) begin
            seg = HEX_SEG[glyph[3:0]];
        end else begin
            case (glyph)
                GLYPH_DASH: seg = SEG_DASH;
                GLYPH_L:    seg = SEG_L;
                default:    seg = SEG_OFF;
            endcase
        end
        return seg;
    endfunction

endpackage

// File: rtl/sevenseg_glyph_dec.sv
// rtl/sevenseg_glyph_dec.sv - combinational 5-bit glyph code to active-low segment decoder
module sevenseg_glyph_dec
    import sevenseg_pkg::*;
(
    input  logic [4:0] glyph,
    output logic [6:0] seg
);

    always_comb begin
        seg = glyph_to_seg(glyph);
    end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// rtl/sevenseg_scan_ctrl.sv - multiplexed common-anode scan controller with PWM, blanking and frame-synchronous load
// Optional per-digit blinking is built when SEVENSEG_BLINK_EN is defined.
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_TICKS  = 100000,
    parameter int BLANK_TICKS  = 200,
    parameter int PWM_BITS     = 4,
    parameter int BLINK_FRAMES = 250,
    parameter int SIMULATE     = 0
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [5*NUM_DIGITS-1:0] d,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blink,
    input  logic [PWM_BITS-1:0]     brightness,
    input  logic                    load,
    output logic                    load_ack,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int DWELL = (SIMULATE != 0) ? 16 : DIGIT_TICKS;
    localparam int GAP   = (SIMULATE != 0) ? 2  : BLANK_TICKS;
    localparam int CNT_W = $clog2(DWELL);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_GAP_LAST = CNT_W'(GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]    dwell_cnt;
    logic [IDX_W-1:0]    idx;
    logic [PWM_BITS-1:0] pwm_cnt;
    scan_state_t         state, state_next;
    logic                dwell_end, wrap;

    logic [4:0]            stage_glyph  [NUM_DIGITS];
    logic [4:0]            shadow_glyph [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] stage_dp, shadow_dp;
    logic                  pending;

    logic [4:0]            cur_glyph;
    logic [6:0]            glyph_seg;
    logic                  lit, blink_dark;
    logic [NUM_DIGITS-1:0] an_next;

    assign dwell_end = (dwell_cnt == CNT_LAST);
    assign wrap      = dwell_end && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell_cnt <= '0;
            idx       <= '0;
            pwm_cnt   <= '0;
            state     <= BLANK;
        end else begin
            dwell_cnt <= dwell_end ? '0 : dwell_cnt + CNT_W'(1);
            if (dwell_end) begin
                idx <= wrap ? '0 : idx + IDX_W'(1);
            end
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            state   <= state_next;
        end
    end

    // State tracks the dwell counter: blank for the first GAP counts of every dwell.
    always_comb begin
        state_next = state;
        case (state)
            BLANK: if (dwell_cnt == CNT_GAP_LAST && !dwell_end) state_next = DRIVE;
            DRIVE: if (dwell_end) state_next = BLANK;
            default: state_next = BLANK;
        endcase
    end

    // Staging absorbs loads at any time; shadow only changes on the frame wrap so a frame never tears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                stage_glyph[i]  <= GLYPH_BLANK;
                shadow_glyph[i] <= GLYPH_BLANK;
            end
            stage_dp  <= '0;
            shadow_dp <= '0;
            pending   <= 1'b0;
            load_ack  <= 1'b0;
        end else begin
            load_ack <= wrap && pending;
            if (wrap && pending) begin
                shadow_glyph <= stage_glyph;
                shadow_dp    <= stage_dp;
            end
            if (load) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    stage_glyph[i] <= d[5*i +: 5];
                end
                stage_dp <= dp;
                pending  <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

`ifdef SEVENSEG_BLINK_EN
    localparam int BLINK_LEN = (SIMULATE != 0) ? 2 : BLINK_FRAMES;
    localparam int FRAME_W   = $clog2(BLINK_LEN + 1);

    logic [NUM_DIGITS-1:0] stage_blink, shadow_blink;
    logic [FRAME_W-1:0]    frame_cnt;
    logic                  blink_phase;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_blink  <= '0;
            shadow_blink <= '0;
            frame_cnt    <= '0;
            blink_phase  <= 1'b0;
        end else begin
            if (wrap && pending) shadow_blink <= stage_blink;
            if (load) stage_blink <= blink;
            if (wrap) begin
                if (frame_cnt == FRAME_W'(BLINK_LEN - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + FRAME_W'(1);
                end
            end
        end
    end

    assign blink_dark = blink_phase && shadow_blink[idx];
`else
    localparam int UNUSED_BLINK_FRAMES = BLINK_FRAMES;
    logic unused_blink;
    assign unused_blink = ^blink;
    assign blink_dark   = 1'b0;
`endif

    assign cur_glyph = shadow_glyph[idx];

    sevenseg_glyph_dec u_glyph_dec (
        .glyph (cur_glyph),
        .seg   (glyph_seg)
    );

    // Full brightness bypasses the compare so the last PWM slot is lit too.
    always_comb begin
        lit     = (brightness == '1) || (pwm_cnt < brightness);
        an_next = '1;
        if (state == DRIVE && lit && !blink_dark) begin
            an_next[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an   <= '1;
            seg  <= SEG_OFF;
            dp_n <= 1'b1;
        end else begin
            an   <= an_next;
            seg  <= glyph_seg;
            dp_n <= ~shadow_dp[idx];
        end
    end

endmodule
